writeback_regfile: RTL

- Writeback stage and architectural register file of the pipelined RV32I core.
- Sits directly downstream of the MEM/WB pipeline register. It consumes that register's W-stage outputs, selects the writeback result and commits it to x1..x31.
- Serves the two decode-stage read ports, with internal write-to-read bypass.
- Exposes ResultW for the hazard/forwarding unit, a0 for top-level test observation, and a retired-write counter.

---
 rtl/writeback_regfile.sv | 116 +++++++++++
 1 files changed

// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file of the pipelined RV32I core.
// Selects the writeback result from the MEM/WB outputs and commits it to
// x1..x31. Serves two combinational decode read ports with write-to-read
// bypass, exposes a0 (x10) for observation and counts retired register writes.
module writeback_regfile #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   // W-stage controls from the MEM/WB pipeline register
   input  logic                     RegWriteW,
   input  logic                     ResultSrcW,
   input  logic                     MUXJUMPW,
   input  logic                     JUMPRTW,
   // W-stage data from the MEM/WB pipeline register
   input  logic [DATA_WIDTH-1:0]    ALUResultW,
   input  logic [DATA_WIDTH-1:0]    ReadDataW,
   input  logic [ADDRESS_WIDTH-1:0] RdW,
   input  logic [DATA_WIDTH-1:0]    PCTargetW,
   input  logic [DATA_WIDTH-1:0]    PCPlus4W,
   // Decode-stage read ports
   input  logic [ADDRESS_WIDTH-1:0] A1,
   input  logic [ADDRESS_WIDTH-1:0] A2,
   output logic [DATA_WIDTH-1:0]    RD1,
   output logic [DATA_WIDTH-1:0]    RD2,
   // Observation outputs
   output logic [DATA_WIDTH-1:0]    ResultW,
   output logic [DATA_WIDTH-1:0]    a0,
   output logic [31:0]              WbCount
);

   localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] A0_INDEX = ADDRESS_WIDTH'(10);

   // Register storage; entry 0 exists for uniform indexing but is never written.
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [31:0]           wb_count_q;
   logic [31:0]           wb_count_d;
   logic [DATA_WIDTH-1:0] result_d;
   logic                  wr_en;

   // Writeback result select, fixed priority: link > PC target > load > ALU.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch is inferred.
      result_d = ALUResultW;
      if (MUXJUMPW) begin
         result_d = PCPlus4W;
      end else if (JUMPRTW) begin
         result_d = PCTargetW;
      end else if (ResultSrcW) begin
         result_d = ReadDataW;
      end
   end

   assign ResultW = result_d;

   // A write retires only when enabled and aimed at a real register; the
   // RegWriteW term is first so unknown RdW while idle resolves to no write.
   assign wr_en = RegWriteW && (RdW != '0);

   // Retired-write counter next state; wraps silently at 2**32.
   always_comb begin
      wb_count_d = wb_count_q;
      if (wr_en) begin
         wb_count_d = wb_count_q + 32'd1;
      end
   end

   // Register file commit; reset clears every entry and beats a same-edge write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the whole array is reset because architectural state must read 0 after reset; this forces flops rather than RAM.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         // NOTE: sequential state uses non-blocking assignment so same-edge readers see the pre-edge value.
         regs_q[RdW] <= result_d;
      end
   end

   // Retired-write counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_count_q <= '0;
      end else begin
         wb_count_q <= wb_count_d;
      end
   end

   // Read port 1: x0 is hard zero, a same-cycle write to A1 is bypassed.
   always_comb begin
      RD1 = regs_q[A1];
      if (A1 == '0) begin
         RD1 = '0;
      end else if (RegWriteW && (RdW == A1)) begin
         RD1 = result_d;
      end
   end

   // Read port 2: same policy as port 1, evaluated independently.
   always_comb begin
      RD2 = regs_q[A2];
      if (A2 == '0) begin
         RD2 = '0;
      end else if (RegWriteW && (RdW == A2)) begin
         RD2 = result_d;
      end
   end

   // a0 shows committed state only; it is deliberately not bypassed.
   assign a0      = regs_q[A0_INDEX];
   assign WbCount = wb_count_q;

endmodule
